// File: rtl/uart_frame_assembler.sv
// Packs UART bytes little-endian into samples, stores one frame, hands it to the FFT via valid/ack.
// Optional idle timeout for partial frames: define ASSEMBLER_TIMEOUT_EN.
module uart_frame_assembler #(
    parameter int FFT_SIZE       = 16,
    parameter int WORD_SIZE      = 16,
    parameter int DATA_LENGTH    = 8,
    parameter int STAGES         = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_byte_valid,
    input  logic [DATA_LENGTH-1:0] i_byte,
    input  logic                   i_byte_error,
    input  logic [STAGES-1:0]      i_rd_addr,
    output logic [WORD_SIZE-1:0]   o_rd_data,
    output logic                   o_frame_valid,
    input  logic                   i_frame_ack,
    output logic [STAGES:0]        o_sample_cnt,
    output logic                   o_overrun,
    output logic                   o_discard
);

    localparam int BYTES = WORD_SIZE / DATA_LENGTH;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [STAGES:0]        sample_cnt_q, sample_cnt_d;
    logic [WORD_SIZE-1:0]   asm_q, asm_d;
    logic                   overrun_q, overrun_d;
    logic                   discard_q, discard_d;
    logic [WORD_SIZE-1:0]   rd_data_q;

    logic [BCW-1:0]         base_byte;
    logic [STAGES:0]        base_sample;
    logic [WORD_SIZE-1:0]   merged_word;
    logic                   accept;
    logic                   wr_en;
    logic [STAGES-1:0]      wr_addr;

    logic [WORD_SIZE-1:0]   frame_mem [FFT_SIZE];

    // Incoming byte replaces the lane selected by the (possibly ack-restarted) byte counter.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign merged_word[gi*DATA_LENGTH +: DATA_LENGTH] =
            (base_byte == BCW'(gi)) ? i_byte : asm_q[gi*DATA_LENGTH +: DATA_LENGTH];
    end

`ifdef ASSEMBLER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;
    logic          timeout_hit;

    always_comb begin
        idle_d      = '0;
        timeout_hit = 1'b0;
        if (state_q == COLLECT && (byte_cnt_q != '0 || sample_cnt_q != '0) && !i_byte_valid) begin
            if (idle_q + IW'(1) == IW'(TIMEOUT_CYCLES)) begin
                timeout_hit = 1'b1;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
    // Partial frames wait indefinitely; TIMEOUT_CYCLES only sizes the optional idle counter.
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        sample_cnt_d = sample_cnt_q;
        asm_d        = asm_q;
        overrun_d    = 1'b0;
        discard_d    = 1'b0;
        accept       = 1'b0;
        wr_en        = 1'b0;
        base_byte    = byte_cnt_q;
        base_sample  = sample_cnt_q;

        case (state_q)
            COLLECT: begin
                if (i_byte_valid && i_byte_error) begin
                    byte_cnt_d   = '0;
                    sample_cnt_d = '0;
                    discard_d    = 1'b1;
                end else if (i_byte_valid) begin
                    accept = 1'b1;
                end else if (timeout_hit) begin
                    byte_cnt_d   = '0;
                    sample_cnt_d = '0;
                    discard_d    = 1'b1;
                end
            end
            FULL: begin
                if (i_frame_ack) begin
                    state_d      = COLLECT;
                    byte_cnt_d   = '0;
                    sample_cnt_d = '0;
                    base_byte    = '0;
                    base_sample  = '0;
                    if (i_byte_valid && i_byte_error) begin
                        discard_d = 1'b1;
                    end else if (i_byte_valid) begin
                        accept = 1'b1;
                    end
                end else if (i_byte_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (accept) begin
            asm_d = merged_word;
            if (base_byte == BCW'(BYTES - 1)) begin
                wr_en        = 1'b1;
                byte_cnt_d   = '0;
                sample_cnt_d = base_sample + 1'b1;
                if (base_sample == (STAGES+1)'(FFT_SIZE - 1)) begin
                    state_d = FULL;
                end
            end else begin
                byte_cnt_d = base_byte + 1'b1;
            end
        end
    end

    assign wr_addr = base_sample[STAGES-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= COLLECT;
            byte_cnt_q   <= '0;
            sample_cnt_q <= '0;
            asm_q        <= '0;
            overrun_q    <= 1'b0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            asm_q        <= asm_d;
            overrun_q    <= overrun_d;
            discard_q    <= discard_d;
        end
    end

    // Frame RAM: no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            frame_mem[wr_addr] <= merged_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= frame_mem[i_rd_addr];
        end
    end

    assign o_rd_data     = rd_data_q;
    assign o_frame_valid = (state_q == FULL);
    assign o_sample_cnt  = sample_cnt_q;
    assign o_overrun     = overrun_q;
    assign o_discard     = discard_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: frame fill, overrun, ack handshake, error discard, reset, timeout.
module tb_uart_frame_assembler;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_error;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_valid;
    logic        frame_ack;
    logic [4:0]  sample_cnt;
    logic        overrun;
    logic        discard;

    int n_checks = 0;
    int n_fail   = 0;

    uart_frame_assembler #(
        .FFT_SIZE(16), .WORD_SIZE(16), .DATA_LENGTH(8), .STAGES(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_byte_valid(byte_valid),
        .i_byte(byte_in),
        .i_byte_error(byte_error),
        .i_rd_addr(rd_addr),
        .o_rd_data(rd_data),
        .o_frame_valid(frame_valid),
        .i_frame_ack(frame_ack),
        .o_sample_cnt(sample_cnt),
        .o_overrun(overrun),
        .o_discard(discard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        byte_valid = 1'b1;
        byte_in    = b;
        byte_error = err;
        tick();
        byte_valid = 1'b0;
        byte_error = 1'b0;
    endtask

    // Sends n bytes start, start+1, ...; counts any overrun pulse seen.
    task automatic send_seq(input logic [7:0] start, input int n, output int ovr_seen);
        ovr_seen = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(start + 8'(i), 1'b0);
            if (overrun) ovr_seen++;
        end
    endtask

    task automatic read_word(input logic [3:0] a, output logic [15:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    logic [15:0] d;
    int          ovr;
    int          idle_cnt;

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_in = '0; byte_error = 1'b0;
        rd_addr = '0; frame_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset frame_valid", {31'b0, frame_valid}, 32'd0);
        check("reset sample_cnt", {27'b0, sample_cnt}, 32'd0);
        check("reset overrun", {31'b0, overrun}, 32'd0);
        check("reset discard", {31'b0, discard}, 32'd0);
        check("reset rd_data", {16'b0, rd_data}, 32'd0);

        // Test 1: full frame of 0x00..0x1F
        send_seq(8'h00, 31, ovr);
        check("t1 not valid before last", {31'b0, frame_valid}, 32'd0);
        check("t1 cnt before last", {27'b0, sample_cnt}, 32'd15);
        send_byte(8'h1F, 1'b0);
        check("t1 frame_valid", {31'b0, frame_valid}, 32'd1);
        check("t1 sample_cnt", {27'b0, sample_cnt}, 32'd16);
        read_word(4'd0, d);  check("t1 addr0", {16'b0, d}, 32'h0100);
        read_word(4'd15, d); check("t1 addr15", {16'b0, d}, 32'h1F1E);
        read_word(4'd5, d);  check("t1 addr5", {16'b0, d}, 32'h0B0A);

        // Test 2: overrun in FULL, then ack
        send_byte(8'hAA, 1'b0);
        check("t2 overrun pulse", {31'b0, overrun}, 32'd1);
        tick();
        check("t2 overrun one cycle", {31'b0, overrun}, 32'd0);
        read_word(4'd0, d);  check("t2 addr0 frozen", {16'b0, d}, 32'h0100);
        check("t2 still valid", {31'b0, frame_valid}, 32'd1);
        ack();
        check("t2 valid after ack", {31'b0, frame_valid}, 32'd0);
        check("t2 cnt after ack", {27'b0, sample_cnt}, 32'd0);
        ack();
        check("t2 ack in collect ignored", {27'b0, sample_cnt}, 32'd0);

        // Test 3: ack coincident with first byte of the next frame
        send_seq(8'h00, 32, ovr);
        check("t3 refill valid", {31'b0, frame_valid}, 32'd1);
        frame_ack = 1'b1;
        send_byte(8'h55, 1'b0);
        frame_ack = 1'b0;
        check("t3 no overrun on ack+byte", {31'b0, overrun}, 32'd0);
        check("t3 valid cleared", {31'b0, frame_valid}, 32'd0);
        send_seq(8'h01, 31, ovr);
        check("t3 overruns seen", ovr, 32'd0);
        check("t3 frame_valid", {31'b0, frame_valid}, 32'd1);
        read_word(4'd0, d);  check("t3 addr0", {16'b0, d}, 32'h0155);
        read_word(4'd15, d); check("t3 addr15", {16'b0, d}, 32'h1F1E);
        ack();

        // Test 4: framing error discards partial frame
        send_seq(8'h40, 5, ovr);
        check("t4 cnt after 5 bytes", {27'b0, sample_cnt}, 32'd2);
        send_byte(8'h99, 1'b1);
        check("t4 discard pulse", {31'b0, discard}, 32'd1);
        check("t4 cnt cleared", {27'b0, sample_cnt}, 32'd0);
        tick();
        check("t4 discard one cycle", {31'b0, discard}, 32'd0);
        send_seq(8'h00, 32, ovr);
        check("t4 frame_valid", {31'b0, frame_valid}, 32'd1);
        read_word(4'd0, d);  check("t4 addr0", {16'b0, d}, 32'h0100);
        read_word(4'd7, d);  check("t4 addr7", {16'b0, d}, 32'h0F0E);
        read_word(4'd2, d);  check("t4 addr2", {16'b0, d}, 32'h0504);
        ack();

        // Test 5: reset mid-frame
        send_seq(8'h60, 10, ovr);
        check("t5 cnt before reset", {27'b0, sample_cnt}, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 rst frame_valid", {31'b0, frame_valid}, 32'd0);
        check("t5 rst sample_cnt", {27'b0, sample_cnt}, 32'd0);
        check("t5 rst rd_data", {16'b0, rd_data}, 32'd0);
        check("t5 rst discard", {31'b0, discard}, 32'd0);
        send_seq(8'h20, 32, ovr);
        check("t5 frame_valid", {31'b0, frame_valid}, 32'd1);
        read_word(4'd0, d);  check("t5 addr0", {16'b0, d}, 32'h2120);
        read_word(4'd15, d); check("t5 addr15", {16'b0, d}, 32'h3F3E);
        ack();

        // Test 6: idle timeout (TIMEOUT_CYCLES = 50)
        send_seq(8'h00, 3, ovr);
        check("t6 cnt after 3 bytes", {27'b0, sample_cnt}, 32'd1);
`ifdef ASSEMBLER_TIMEOUT_EN
        idle_cnt = 0;
        while (!discard && idle_cnt < 80) begin
            tick();
            idle_cnt++;
        end
        check("t6 timeout idle cycles", idle_cnt, 32'd50);
        check("t6 timeout discard", {31'b0, discard}, 32'd1);
        check("t6 timeout cnt cleared", {27'b0, sample_cnt}, 32'd0);
        tick();
        check("t6 discard one cycle", {31'b0, discard}, 32'd0);
        send_seq(8'h00, 32, ovr);
`else
        idle_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (discard) idle_cnt++;
        end
        check("t6 no discard pulses", idle_cnt, 32'd0);
        check("t6 cnt held", {27'b0, sample_cnt}, 32'd1);
        send_seq(8'h03, 29, ovr);
`endif
        check("t6 frame_valid", {31'b0, frame_valid}, 32'd1);
        read_word(4'd1, d);  check("t6 addr1", {16'b0, d}, 32'h0302);
        read_word(4'd15, d); check("t6 addr15", {16'b0, d}, 32'h1F1E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
